bcd_serial_alu: RTL and testbench
=================================

Name: bcd_serial_alu

Overview:
Parametrised digit-serial BCD add/subtract unit, the successor to the fixed 3-digit, fixed-add sum block. It accepts two DIGITS-wide BCD operands one digit per accepted beat, most significant digit first, with a valid/ready handshake. It computes A+B or A-B with decimal correction, one digit per cycle, and reports the result as sign plus magnitude together with carry and error flags. It sits between the keypad/sample front end and the 7-segment display driver.

Parameters:
DIGITS, 3, number of BCD digits per operand and result (1..8)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
sample_valid  in  1  sample carries a digit this cycle
sample  in  4  BCD digit, MSD first, operand A then operand B
mode  in  1  0 = add, 1 = subtract; sampled with the first A digit only
sample_ready  out  1  block accepts a digit this cycle
result_valid  out  1  single-cycle pulse, result fields updated
cdu  out  4*DIGITS  result magnitude, BCD, MSD in top nibble
carry  out  1  add: decimal carry out of MSD (overflow); subtract: always 0
neg  out  1  subtract and A<B; cdu then holds B-A
err  out  1  some accepted digit was >9 in this operation

Behaviour:
- Reset: state LOAD_A, digit counter 0, operand regs 0, cdu=0, carry=0, neg=0, err=0, result_valid=0. Reset mid-operation discards all partial operands. Reset wins over every other event in the same cycle.
- Accept = sample_valid & sample_ready. sample_ready=1 only in LOAD_A and LOAD_B. Gaps in sample_valid simply stall; there is no timeout.
- LOAD_A: each accept shifts the digit into A from the LSD side, so after DIGITS accepts the first digit sits in the top nibble. The first accept latches mode and clears the sticky error. After DIGITS accepts, the block goes to LOAD_B.
- LOAD_B: same as LOAD_A for B. After the last accept the block goes to CALC.
- err: an accepted digit >9 sets sticky err_int. The digit is still stored.
- CALC: DIGITS cycles, LSD first, one bcd_digit_add per cycle.
  - add: a_i + b_i + c, carry in 0.
  - sub: a_i + (9-b_i) + c, carry in 1.
  - Binary sum >9 subtracts 10 and sets carry out.
  - The partial result shifts into the result reg.
- After CALC:
  - add: go to DONE with carry = final carry.
  - sub with final carry 1: A>=B, neg=0, go to DONE.
  - sub with final carry 0: A<B, go to FIX.
- FIX: DIGITS cycles, LSD first. Computes the 10's complement of the raw result (9-r_i + c, carry in 1), then neg=1, go to DONE.
- DONE: one cycle.
  - result_valid=1; cdu, carry, neg, err update on this cycle's edge and hold until the next DONE or reset.
  - If err_int: cdu=0, carry=0, neg=0, err=1.
  - Next state LOAD_A; sample_ready=0 during DONE.
- Latency: last B digit accepted at edge t gives result_valid high in cycle t+DIGITS+1 (add, or sub with A>=B), or t+2*DIGITS+1 (sub with A<B).
- Wrap-around: an add overflow truncates cdu to DIGITS digits and sets carry=1. A subtract never overflows.
- A-B with A==B gives cdu=0, neg=0.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_t (logic [3:0]).
  - state enum {LOAD_A, LOAD_B, CALC, FIX, DONE}.
  - constants MODE_ADD=1'b0, MODE_SUB=1'b1, BCD_MAX=4'd9.
- Sub-module bcd_digit_add: combinational, inputs a, b (bcd_t) and cin; outputs s (bcd_t) and cout; performs the decimal correction. The top module instantiates it once and shares it between CALC and FIX by muxing its operands.

Test Plan:
- DIGITS=3, add 1,2,3 / 4,5,6 -> result_valid 4 cycles after the last B accept; cdu=12'h579, carry=0, neg=0, err=0.
- add 9,9,9 / 0,0,1 -> cdu=12'h000, carry=1; then add 0,0,5 / 0,0,5 back-to-back -> cdu=12'h010, carry=0.
- sub 4,5,6 - 1,2,3 -> cdu=12'h333, neg=0, latency 4. Then sub 1,2,3 - 4,5,6 -> cdu=12'h333, neg=1, latency 7. Then sub 2,0,0 - 2,0,0 -> cdu=0, neg=0.
- sample_valid toggled 1,0,0,1,... across the load -> same 12'h579 result; sample_ready low during CALC/FIX/DONE; digits offered then are ignored.
- A digit 4'hC in operand A -> result_valid with err=1, cdu=0. The next clean operation clears err.
- reset asserted after 4 accepted digits -> all outputs 0 the next cycle, then a full 1,2,3 + 4,5,6 load gives 12'h579.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the digit-serial BCD ALU
//
// Purpose : BCD digit type, ALU state encoding and mode/digit constants.
// Ports   : none (package).
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      CALC,
      FIX,
      DONE
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
   localparam bcd_t BCD_MAX  = 4'd9;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single-digit decimal adder with carry correction
//
// Purpose : s = (a + b + cin) mod 10, cout = (a + b + cin) > 9.
// Ports   : a, b  - BCD digits in
//           cin   - carry in
//           s     - BCD digit out
//           cout  - decimal carry out
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_t a,
   input  bcd_t b,
   input  logic cin,
   output bcd_t s,
   output logic cout
);

   logic [4:0] sum;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      cout = (sum > 5'd9);
      // Non-BCD inputs (err case) can exceed 19; result is discarded then.
      s    = cout ? bcd_t'(sum - 5'd10) : sum[3:0];
   end

endmodule

// File: rtl/bcd_serial_alu.sv
// rtl/bcd_serial_alu.sv - digit-serial BCD add/subtract unit, sign-magnitude result
//
// Purpose : loads A then B one digit per accepted beat (MSD first), computes
//           A+B or A-B LSD first with one shared digit adder, and presents a
//           sign-magnitude result with carry and error flags.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           sample_valid/ready  - digit handshake
//           sample              - BCD digit in
//           mode                - 0 add, 1 subtract (taken with first A digit)
//           result_valid        - one-cycle pulse when result fields update
//           cdu                 - result magnitude, MSD in top nibble
//           carry, neg, err     - add overflow, negative result, bad digit seen
module bcd_serial_alu
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [3:0]          sample,
   input  logic                mode,
   output logic                sample_ready,
   output logic                result_valid,
   output logic [4*DIGITS-1:0] cdu,
   output logic                carry,
   output logic                neg,
   output logic                err
);

   localparam int         DW   = 4 * DIGITS;
   localparam logic [3:0] LAST = 4'(DIGITS - 1);

   state_e          state_q;
   logic [3:0]      cnt_q;
   logic [DW-1:0]   a_q, b_q, r_q;
   logic            mode_q, err_int_q, neg_int_q, c_q;
   logic [DW-1:0]   cdu_q;
   logic            carry_q, neg_q, err_q, result_valid_q;

   bcd_t add_a, add_b, add_s;
   logic add_cin, add_cout;
   logic accept, last_digit, bad_digit;

   assign sample_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign accept       = sample_valid && sample_ready;
   assign last_digit   = (cnt_q == LAST);
   assign bad_digit    = (sample > BCD_MAX);

   // One adder shared: CALC consumes operand LSDs, FIX complements the raw result.
   always_comb begin
      add_cin = c_q;
      add_a   = a_q[3:0];
      add_b   = (mode_q == MODE_SUB) ? BCD_MAX - b_q[3:0] : b_q[3:0];
      if (state_q == FIX) begin
         add_a = '0;
         add_b = BCD_MAX - r_q[3:0];
      end
   end

   bcd_digit_add u_digit_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .s    (add_s),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= LOAD_A;
         cnt_q          <= '0;
         a_q            <= '0;
         b_q            <= '0;
         r_q            <= '0;
         mode_q         <= MODE_ADD;
         err_int_q      <= 1'b0;
         neg_int_q      <= 1'b0;
         c_q            <= 1'b0;
         cdu_q          <= '0;
         carry_q        <= 1'b0;
         neg_q          <= 1'b0;
         err_q          <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         case (state_q)
            LOAD_A: begin
               if (accept) begin
                  a_q <= (a_q << 4) | DW'(sample);
                  if (cnt_q == '0) begin
                     mode_q    <= mode;
                     err_int_q <= bad_digit;
                     neg_int_q <= 1'b0;
                  end else if (bad_digit) begin
                     err_int_q <= 1'b1;
                  end
                  if (last_digit) begin
                     cnt_q   <= '0;
                     state_q <= LOAD_B;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            LOAD_B: begin
               if (accept) begin
                  b_q <= (b_q << 4) | DW'(sample);
                  if (bad_digit) err_int_q <= 1'b1;
                  if (last_digit) begin
                     cnt_q   <= '0;
                     c_q     <= mode_q;   // subtract adds 1 for the 10's complement of B
                     state_q <= CALC;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            CALC: begin
               a_q <= a_q >> 4;
               b_q <= b_q >> 4;
               r_q <= (r_q >> 4) | (DW'(add_s) << (DW - 4));
               c_q <= add_cout;
               if (last_digit) begin
                  cnt_q <= '0;
                  if (mode_q == MODE_ADD || add_cout) begin
                     state_q <= DONE;
                  end else begin
                     // No final carry on subtract means A<B: raw result is 10's complement.
                     c_q       <= 1'b1;
                     neg_int_q <= 1'b1;
                     state_q   <= FIX;
                  end
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            FIX: begin
               r_q <= (r_q >> 4) | (DW'(add_s) << (DW - 4));
               c_q <= add_cout;
               if (last_digit) begin
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            DONE: begin
               result_valid_q <= 1'b1;
               cdu_q          <= err_int_q ? '0 : r_q;
               carry_q        <= !err_int_q && (mode_q == MODE_ADD) && c_q;
               neg_q          <= !err_int_q && neg_int_q;
               err_q          <= err_int_q;
               cnt_q          <= '0;
               state_q        <= LOAD_A;
            end
            default: state_q <= LOAD_A;
         endcase
      end
   end

   assign result_valid = result_valid_q;
   assign cdu          = cdu_q;
   assign carry        = carry_q;
   assign neg          = neg_q;
   assign err          = err_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// tb/tb_bcd_serial_alu.sv - directed vector bench for bcd_serial_alu (DIGITS=3)
module tb_bcd_serial_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [3:0]  sample;
   logic        mode;
   logic        sample_ready;
   logic        result_valid;
   logic [11:0] cdu;
   logic        carry, neg, err;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bcd_serial_alu #(.DIGITS(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample       (sample),
      .mode         (mode),
      .sample_ready (sample_ready),
      .result_valid (result_valid),
      .cdu          (cdu),
      .carry        (carry),
      .neg          (neg),
      .err          (err)
   );

   typedef struct {
      logic        m;
      logic [11:0] a;
      logic [11:0] b;
      logic        gap;
      logic [11:0] x_cdu;
      logic        x_c;
      logic        x_n;
      logic        x_e;
      int          x_lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts and ends on a falling edge. Offers junk 4'hF while busy.
   task automatic run_op(input logic m, input logic [11:0] a, input logic [11:0] b,
                         input logic gap, output int lat, output int ready_bad);
      logic [3:0] d;
      ready_bad = 0;
      for (int i = 0; i < 6; i++) begin
         d = (i < 3) ? a[4*(2-i) +: 4] : b[4*(5-i) +: 4];
         if (gap) begin
            sample_valid = 1'b0;
            repeat (2) @(negedge clk);
         end
         sample_valid = 1'b1;
         sample       = d;
         mode         = (i == 0) ? m : ~m;
         if (!sample_ready) ready_bad++;
         @(posedge clk);
         @(negedge clk);
      end
      sample = 4'hF;
      lat = 0;
      while (1) begin
         @(posedge clk);
         #1;
         lat++;
         if (result_valid || lat > 30) break;
         if (sample_ready) ready_bad++;
      end
      sample_valid = 1'b0;
   endtask

   int lat, rbad;

   initial begin
      vecs[0]  = '{1'b0, 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 1'b0, 4};
      vecs[1]  = '{1'b0, 12'h999, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4};
      vecs[2]  = '{1'b0, 12'h005, 12'h005, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0, 4};
      vecs[3]  = '{1'b1, 12'h456, 12'h123, 1'b0, 12'h333, 1'b0, 1'b0, 1'b0, 4};
      vecs[4]  = '{1'b1, 12'h123, 12'h456, 1'b0, 12'h333, 1'b0, 1'b1, 1'b0, 7};
      vecs[5]  = '{1'b1, 12'h200, 12'h200, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4};
      vecs[6]  = '{1'b0, 12'h123, 12'h456, 1'b1, 12'h579, 1'b0, 1'b0, 1'b0, 4};
      vecs[7]  = '{1'b0, 12'hC23, 12'h456, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4};
      vecs[8]  = '{1'b0, 12'h111, 12'h222, 1'b0, 12'h333, 1'b0, 1'b0, 1'b0, 4};
      vecs[9]  = '{1'b1, 12'h000, 12'h001, 1'b0, 12'h001, 1'b0, 1'b1, 1'b0, 7};
      vecs[10] = '{1'b1, 12'h500, 12'h499, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 4};
      vecs[11] = '{1'b0, 12'h999, 12'h999, 1'b0, 12'h998, 1'b1, 1'b0, 1'b0, 4};

      reset = 1'b1;
      sample_valid = 1'b0;
      sample = 4'h0;
      mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cdu", int'(cdu), 0);
      chk("reset_rv", int'(result_valid), 0);
      chk("reset_flags", int'({carry, neg, err}), 0);
      chk("reset_ready", int'(sample_ready), 1);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 12; k++) begin
         run_op(vecs[k].m, vecs[k].a, vecs[k].b, vecs[k].gap, lat, rbad);
         chk($sformatf("v%0d_latency", k), lat, vecs[k].x_lat);
         chk($sformatf("v%0d_cdu", k), int'(cdu), int'(vecs[k].x_cdu));
         chk($sformatf("v%0d_carry", k), int'(carry), int'(vecs[k].x_c));
         chk($sformatf("v%0d_neg", k), int'(neg), int'(vecs[k].x_n));
         chk($sformatf("v%0d_err", k), int'(err), int'(vecs[k].x_e));
         chk($sformatf("v%0d_ready", k), rbad, 0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pulse", k), int'(result_valid), 0);
         @(negedge clk);
      end

      // Reset after four accepted digits discards the partial operands.
      for (int i = 0; i < 4; i++) begin
         sample_valid = 1'b1;
         sample = 4'(i + 1);
         mode = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_cdu", int'(cdu), 0);
      chk("midreset_flags", int'({carry, neg, err, result_valid}), 0);
      chk("midreset_ready", int'(sample_ready), 1);
      @(negedge clk);
      reset = 1'b0;
      run_op(1'b0, 12'h123, 12'h456, 1'b0, lat, rbad);
      chk("post_reset_latency", lat, 4);
      chk("post_reset_cdu", int'(cdu), 12'h579);
      chk("post_reset_flags", int'({carry, neg, err}), 0);
      chk("post_reset_ready", rbad, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
